vga_pattern_sequencer: RTL and testbench
========================================

// Module: vga_pattern_sequencer
// PURPOSE
// Selects which test pattern the pixel datapath draws. Patterns change only at
// frame boundaries, so no frame ever shows a mix of two patterns. Two sources
// can request a change: a debounced push-button (manual step) and an
// auto-cycle timer that counts frames. Sits between the board I/O / VGA timing
// generator and the pattern colour logic, in the 25 MHz pixel-clock domain.
// PARAMETERS
// NUM_PATTERNS    6       number of selectable patterns; pattern_sel wraps NUM_PATTERNS-1 -> 0
// SEL_W           3       width of pattern_sel; must satisfy 2**SEL_W >= NUM_PATTERNS
// DEBOUNCE_CYCLES 250000  consecutive stable cycles needed to accept a button level (10 ms @ 25 MHz)
// AUTO_FRAMES     120     frames per pattern in auto mode (2 s @ 60 Hz); must be >= 1
// CNT_W           8       frame counter width; must satisfy 2**CNT_W >= AUTO_FRAMES
// PORTS
// clk          in   1      pixel clock (25 MHz)
// rst          in   1      asynchronous reset, active-high
// frame_start  in   1      1-cycle pulse from timing generator at start of vertical blanking
// btn_next     in   1      raw push-button, asynchronous, bounces
// auto_en      in   1      raw slide switch, asynchronous; 1 = auto-cycle mode
// pattern_sel  out  SEL_W  current pattern index, registered
// sel_update   out  1      1-cycle pulse in the cycle pattern_sel takes a new value
// auto_active  out  1      1 while the FSM is in S_AUTO
// frame_cnt    out  CNT_W  frames elapsed in the current auto period
// BEHAVIOUR
// - Reset (rst=1, async, also mid-operation): pattern_sel=0, sel_update=0, auto_active=0,
//   frame_cnt=0, pending=0, debounced level=0, debounce count=0, synchronisers=0, FSM=S_MANUAL.
// - btn_next and auto_en each pass through a 2-FF synchroniser. auto_en is not debounced.
// - Debounce: the counter increments while sync_btn != btn_db and clears when they match.
//   When sync_btn still differs at count == DEBOUNCE_CYCLES-1, btn_db <= sync_btn and the
//   counter clears. A change therefore needs DEBOUNCE_CYCLES consecutive differing cycles.
// - btn_rise = btn_db & ~btn_db_q, a 1-cycle pulse. Only rising edges request a step.
// - pending: pending_next = (pending & ~commit) | btn_rise.
//   Multiple presses within one frame still give a single step.
//   A btn_rise in the same cycle as commit stays pending and is committed at the next frame.
// - FSM states:
//   S_MANUAL: on sync_auto=1, go to S_AUTO and clear frame_cnt.
//   S_AUTO:   on sync_auto=0, go to S_MANUAL and hold frame_cnt at 0.
// - frame_cnt, in S_AUTO only, on each frame_start: if frame_cnt == AUTO_FRAMES-1 then
//   auto_tick=1 and frame_cnt <= 0, else frame_cnt <= frame_cnt+1.
// - commit = frame_start & (pending | auto_tick). The button also works in S_AUTO.
// - On commit: pattern_sel <= (pattern_sel == NUM_PATTERNS-1) ? 0 : pattern_sel+1,
//   and sel_update=1 for exactly the next cycle.
//   Pending and auto_tick together give ONE increment, and both are consumed.
// - Latency: frame_start in cycle n -> new pattern_sel and sel_update visible in cycle n+1.
//   Raw button edge to pending set: 2 + DEBOUNCE_CYCLES + 1 cycles.
// - pattern_sel never changes without frame_start. Without frame pulses, requests stay pending.
// - pattern_sel never leaves 0..NUM_PATTERNS-1. If NUM_PATTERNS=1, commit is accepted but
//   pattern_sel stays 0.
// TESTING (bench parameters: NUM_PATTERNS=6, DEBOUNCE_CYCLES=4, AUTO_FRAMES=3)
// 1 btn_next high for 3 cycles, low, then frame_start -> pattern_sel stays 0, sel_update never 1.
// 2 btn_next held 10 cycles, two such presses, then one frame_start -> pattern_sel 0->1 the cycle
//   after frame_start, a single 1-cycle sel_update; a second frame_start gives no change.
// 3 Force pattern_sel to 5 via 5 committed presses, press again, frame_start -> pattern_sel=0.
// 4 auto_en=1, three frame_starts -> frame_cnt goes 0,1,2 then 0; pattern_sel +1 on the third only.
//   Press pending at that same third frame -> still +1 total.
// 5 Press debounced, no frame_start for 1000 cycles -> pattern_sel unchanged; the first
//   frame_start then commits.
// 6 Assert rst mid-debounce with pending=1 and pattern_sel=3 -> all outputs 0 immediately;
//   after release, frame_start gives no step.

Source files
------------

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern selector for the VGA pixel datapath. Pattern changes are
// requested by a debounced push-button or by an auto-cycle frame timer. They
// are applied only on frame_start, so a frame never shows two patterns.
module vga_pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS    = 6,
    parameter int unsigned SEL_W           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned AUTO_FRAMES     = 120,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             frame_start_i,
    input  logic             btn_next_i,
    input  logic             auto_en_i,
    output logic [SEL_W-1:0] pattern_sel_o,
    output logic             sel_update_o,
    output logic             auto_active_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTO_FRAMES - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_PATTERNS - 1);

    typedef enum logic [0:0] {StManual, StAuto} state_e;

    logic            btn_meta_q, btn_sync_q;
    logic            auto_meta_q, auto_sync_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic            btn_db_dly_q;
    logic            btn_rise;
    logic            pending_q, pending_d;
    state_e          state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            auto_tick;
    logic            commit;
    logic [SEL_W-1:0] pattern_sel_q, pattern_sel_d;
    logic            sel_update_q;

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            auto_meta_q <= 1'b0;
            auto_sync_q <= 1'b0;
        end else begin
            btn_meta_q  <= btn_next_i;
            btn_sync_q  <= btn_meta_q;
            auto_meta_q <= auto_en_i;
            auto_sync_q <= auto_meta_q;
        end
    end

    // Debounce: accept the new level only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_sync_q != btn_db_q) begin
            if (db_cnt_q == DB_MAX) begin
                btn_db_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign btn_rise = btn_db_q & ~btn_db_dly_q;

    // FSM next state and auto-cycle frame counter.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        auto_tick   = 1'b0;
        case (state_q)
            StManual: begin
                frame_cnt_d = '0;
                if (auto_sync_q) begin
                    state_d = StAuto;
                end
            end
            StAuto: begin
                if (!auto_sync_q) begin
                    state_d     = StManual;
                    frame_cnt_d = '0;
                end else if (frame_start_i) begin
                    if (frame_cnt_q == CNT_MAX) begin
                        auto_tick   = 1'b1;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = StManual;
                frame_cnt_d = '0;
            end
        endcase
    end

    // Commit on frame boundaries; a button press and an auto tick together step once.
    always_comb begin
        commit        = frame_start_i & (pending_q | auto_tick);
        pending_d     = (pending_q & ~commit) | btn_rise;
        pattern_sel_d = pattern_sel_q;
        if (commit) begin
            pattern_sel_d = (pattern_sel_q >= SEL_MAX) ? '0 : pattern_sel_q + SEL_W'(1);
        end
    end

    // Sequential state for debounce, request tracking, FSM and pattern index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_dly_q  <= 1'b0;
            pending_q     <= 1'b0;
            state_q       <= StManual;
            frame_cnt_q   <= '0;
            pattern_sel_q <= '0;
            sel_update_q  <= 1'b0;
        end else begin
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            btn_db_dly_q  <= btn_db_q;
            pending_q     <= pending_d;
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            pattern_sel_q <= pattern_sel_d;
            sel_update_q  <= commit;
        end
    end

    assign pattern_sel_o = pattern_sel_q;
    assign sel_update_o  = sel_update_q;
    assign auto_active_o = (state_q == StAuto);
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer with short debounce and auto periods.
module tb_vga_pattern_sequencer;

    localparam int unsigned NUM_PATTERNS    = 6;
    localparam int unsigned SEL_W           = 3;
    localparam int unsigned DEBOUNCE_CYCLES = 4;
    localparam int unsigned AUTO_FRAMES     = 3;
    localparam int unsigned CNT_W           = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_start = 1'b0;
    logic             btn_next = 1'b0;
    logic             auto_en = 1'b0;
    logic [SEL_W-1:0] pattern_sel;
    logic             sel_update;
    logic             auto_active;
    logic [CNT_W-1:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int upd_count = 0;

    vga_pattern_sequencer #(
        .NUM_PATTERNS   (NUM_PATTERNS),
        .SEL_W          (SEL_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .AUTO_FRAMES    (AUTO_FRAMES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .frame_start_i(frame_start),
        .btn_next_i   (btn_next),
        .auto_en_i    (auto_en),
        .pattern_sel_o(pattern_sel),
        .sel_update_o (sel_update),
        .auto_active_o(auto_active),
        .frame_cnt_o  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Count sel_update pulses, sampled mid-way between the edges the tasks use.
    always @(posedge clk) begin
        #3;
        if (sel_update === 1'b1) upd_count++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Full press: long enough to debounce the rise, then long enough to debounce the release.
    task automatic press();
        btn_next = 1'b1;
        step(10);
        btn_next = 1'b0;
        step(10);
    endtask

    // One-cycle frame pulse; returns at the negedge of the cycle after the pulse.
    task automatic frame();
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({pattern_sel, sel_update, auto_active, frame_cnt} !== '0)
            $display("FAIL reset_outputs: sel=%0d upd=%0d auto=%0d cnt=%0d, required all 0",
                     pattern_sel, sel_update, auto_active, frame_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_short_glitch();
        int u0 = upd_count;
        btn_next = 1'b1;
        step(3);
        btn_next = 1'b0;
        step(10);
        frame();
        step(2);
        n_checks++;
        if (pattern_sel !== 3'd0)
            $display("FAIL glitch_sel: got %0d, required 0", pattern_sel);
        else n_pass++;
        n_checks++;
        if (upd_count - u0 !== 0)
            $display("FAIL glitch_upd: got %0d pulses, required 0", upd_count - u0);
        else n_pass++;
    endtask

    task automatic test_double_press();
        int u0 = upd_count;
        press();
        press();
        n_checks++;
        if (pattern_sel !== 3'd0)
            $display("FAIL double_no_frame: got %0d, required 0", pattern_sel);
        else n_pass++;
        frame();
        n_checks++;
        if (pattern_sel !== 3'd1 || sel_update !== 1'b1)
            $display("FAIL double_commit: sel=%0d upd=%0d, required sel=1 upd=1",
                     pattern_sel, sel_update);
        else n_pass++;
        step(1);
        n_checks++;
        if (sel_update !== 1'b0)
            $display("FAIL double_upd_width: got %0d, required 0", sel_update);
        else n_pass++;
        frame();
        step(1);
        n_checks++;
        if (pattern_sel !== 3'd1 || upd_count - u0 !== 1)
            $display("FAIL double_second_frame: sel=%0d pulses=%0d, required sel=1 pulses=1",
                     pattern_sel, upd_count - u0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            press();
            frame();
        end
        n_checks++;
        if (pattern_sel !== 3'd5)
            $display("FAIL wrap_reach_max: got %0d, required 5", pattern_sel);
        else n_pass++;
        press();
        frame();
        n_checks++;
        if (pattern_sel !== 3'd0 || sel_update !== 1'b1)
            $display("FAIL wrap_to_zero: sel=%0d upd=%0d, required sel=0 upd=1",
                     pattern_sel, sel_update);
        else n_pass++;
        step(1);
    endtask

    task automatic test_auto();
        int u0;
        auto_en = 1'b1;
        step(4);
        n_checks++;
        if (auto_active !== 1'b1 || frame_cnt !== 8'd0)
            $display("FAIL auto_enter: auto=%0d cnt=%0d, required auto=1 cnt=0",
                     auto_active, frame_cnt);
        else n_pass++;
        u0 = upd_count;
        frame();
        n_checks++;
        if (frame_cnt !== 8'd1 || pattern_sel !== 3'd0)
            $display("FAIL auto_frame1: cnt=%0d sel=%0d, required cnt=1 sel=0",
                     frame_cnt, pattern_sel);
        else n_pass++;
        step(1);
        frame();
        n_checks++;
        if (frame_cnt !== 8'd2 || pattern_sel !== 3'd0)
            $display("FAIL auto_frame2: cnt=%0d sel=%0d, required cnt=2 sel=0",
                     frame_cnt, pattern_sel);
        else n_pass++;
        press();
        frame();
        n_checks++;
        if (frame_cnt !== 8'd0 || pattern_sel !== 3'd1 || sel_update !== 1'b1)
            $display("FAIL auto_tick_and_press: cnt=%0d sel=%0d upd=%0d, required 0/1/1",
                     frame_cnt, pattern_sel, sel_update);
        else n_pass++;
        step(1);
        frame();
        step(1);
        n_checks++;
        if (pattern_sel !== 3'd1 || frame_cnt !== 8'd1 || upd_count - u0 !== 1)
            $display("FAIL auto_consumed: sel=%0d cnt=%0d pulses=%0d, required 1/1/1",
                     pattern_sel, frame_cnt, upd_count - u0);
        else n_pass++;
        auto_en = 1'b0;
        step(4);
        n_checks++;
        if (auto_active !== 1'b0 || frame_cnt !== 8'd0)
            $display("FAIL auto_exit: auto=%0d cnt=%0d, required auto=0 cnt=0",
                     auto_active, frame_cnt);
        else n_pass++;
    endtask

    task automatic test_hold_pending();
        int u0 = upd_count;
        press();
        step(1000);
        n_checks++;
        if (pattern_sel !== 3'd1 || upd_count - u0 !== 0)
            $display("FAIL hold_no_frame: sel=%0d pulses=%0d, required sel=1 pulses=0",
                     pattern_sel, upd_count - u0);
        else n_pass++;
        frame();
        n_checks++;
        if (pattern_sel !== 3'd2 || sel_update !== 1'b1)
            $display("FAIL hold_commit: sel=%0d upd=%0d, required sel=2 upd=1",
                     pattern_sel, sel_update);
        else n_pass++;
        step(1);
    endtask

    task automatic test_mid_reset();
        int u0;
        press();
        frame();
        n_checks++;
        if (pattern_sel !== 3'd3)
            $display("FAIL midrst_setup: got %0d, required 3", pattern_sel);
        else n_pass++;
        step(1);
        press();
        auto_en = 1'b1;
        btn_next = 1'b1;
        step(4);
        n_checks++;
        if (auto_active !== 1'b1)
            $display("FAIL midrst_auto_setup: got %0d, required 1", auto_active);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pattern_sel, sel_update, auto_active, frame_cnt} !== '0)
            $display("FAIL midrst_async: sel=%0d upd=%0d auto=%0d cnt=%0d, required all 0",
                     pattern_sel, sel_update, auto_active, frame_cnt);
        else n_pass++;
        btn_next = 1'b0;
        auto_en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(10);
        u0 = upd_count;
        frame();
        step(1);
        n_checks++;
        if (pattern_sel !== 3'd0 || upd_count - u0 !== 0)
            $display("FAIL midrst_no_step: sel=%0d pulses=%0d, required sel=0 pulses=0",
                     pattern_sel, upd_count - u0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_short_glitch();
        test_double_press();
        test_wrap();
        test_auto();
        test_hold_pending();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
